// File: rtl/shift_register_sequencer.sv
// Command sequencer for a circular shift register: turns LOAD/ROTL/ROTR/READ
// commands into cycle-by-cycle S/D/OE pin activity and reports completion.
module shift_register_sequencer #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    input  logic [AMT_W-1:0] cmd_amt_i,
    output logic [1:0]       s_o,
    output logic [WIDTH-1:0] d_o,
    output logic             oe_o,
    input  logic [WIDTH-1:0] q_i,
    output logic             rsp_valid_o,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(WIDTH / 2 + 1);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ROTL = 2'b01;
    localparam logic [1:0] OP_ROTR = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_LEFT  = 2'b01;
    localparam logic [1:0] S_RIGHT = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        READ_EN,
        READ_CAP
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         s_q, s_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               oe_q, oe_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        effAmt;
    logic [31:0]        stepsFull;
    logic               reverseDir;
    logic               goLeft;
    logic [CNT_W-1:0]   steps;

    // Rotations longer than half the ring are done the short way round;
    // an exact half-turn keeps the requested direction.
    always_comb begin
        effAmt     = 32'(cmd_amt_i) % 32'(WIDTH);
        reverseDir = (effAmt > 32'(WIDTH / 2));
        stepsFull  = reverseDir ? (32'(WIDTH) - effAmt) : effAmt;
        steps      = CNT_W'(stepsFull);
        goLeft     = (cmd_op_i == OP_ROTL) ^ reverseDir;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            s_q         <= S_HOLD;
            d_q         <= '0;
            oe_q        <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            d_q         <= d_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        d_d         = d_q;
        oe_d        = oe_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                s_d  = S_HOLD;
                oe_d = 1'b1;
                if (cmd_valid_i) begin
                    case (cmd_op_i)
                        OP_LOAD: begin
                            state_d = LOAD;
                            s_d     = S_LOAD;
                            d_d     = cmd_data_i;
                        end
                        OP_ROTL, OP_ROTR: begin
                            // Zero-step rotations complete without touching S.
                            if (steps == '0) begin
                                rsp_valid_d = 1'b1;
                            end else begin
                                state_d = SHIFT;
                                s_d     = goLeft ? S_LEFT : S_RIGHT;
                                cnt_d   = steps;
                            end
                        end
                        OP_READ: begin
                            state_d = READ_EN;
                            oe_d    = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            LOAD: begin
                state_d     = IDLE;
                s_d         = S_HOLD;
                rsp_valid_d = 1'b1;
            end
            SHIFT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = IDLE;
                    s_d         = S_HOLD;
                    rsp_valid_d = 1'b1;
                end
            end
            READ_EN: begin
                state_d = READ_CAP;
            end
            READ_CAP: begin
                // Q has had a full cycle to settle since OE dropped.
                rsp_data_d  = q_i;
                oe_d        = 1'b1;
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                s_d     = S_HOLD;
                oe_d    = 1'b1;
            end
        endcase
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign s_o         = s_q;
    assign d_o         = d_q;
    assign oe_o        = oe_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Bench for shift_register_sequencer: drives directed commands against a
// behavioural circular shift register and scoreboards every response.
module tb_shift_register_sequencer;

    logic       clk;
    logic       rst;
    logic       cmdValid;
    logic       cmdReady;
    logic [1:0] cmdOp;
    logic [3:0] cmdData;
    logic [2:0] cmdAmt;
    logic [1:0] sPin;
    logic [3:0] dPin;
    logic       oePin;
    logic [3:0] qPin;
    logic       rspValid;
    logic [3:0] rspData;
    logic       busy;

    logic [3:0] regModel;
    logic [3:0] expQueue[$];
    int         checks = 0;
    int         errors = 0;

    shift_register_sequencer #(.WIDTH(4), .AMT_W(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmdValid),
        .cmd_ready_o (cmdReady),
        .cmd_op_i    (cmdOp),
        .cmd_data_i  (cmdData),
        .cmd_amt_i   (cmdAmt),
        .s_o         (sPin),
        .d_o         (dPin),
        .oe_o        (oePin),
        .q_i         (qPin),
        .rsp_valid_o (rspValid),
        .rsp_data_o  (rspData),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The controlled register: not reset by the sequencer, Q tri-stated while OE=1.
    always @(posedge clk) begin
        case (sPin)
            2'b01:   regModel <= {regModel[2:0], regModel[3]};
            2'b10:   regModel <= {regModel[0], regModel[3:1]};
            2'b11:   regModel <= dPin;
            default: ;
        endcase
    end
    assign qPin = oePin ? 4'bzzzz : regModel;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every completion pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rspValid === 1'b1) begin
            if (expQueue.size() == 0) begin
                checkVal("unexpected_rsp", 32'(rspData), 32'hDEAD);
            end else begin
                checkVal("rsp_data", 32'(rspData), 32'(expQueue.pop_front()));
            end
        end
    end

    // Called at a negedge with the sequencer idle; returns just after the accept edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] data,
                                 input logic [2:0] amt, input logic [3:0] expRsp);
        checkVal("ready_before_cmd", 32'(cmdReady), 32'd1);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdData  = data;
        cmdAmt   = amt;
        expQueue.push_back(expRsp);
        @(posedge clk);
        #1 cmdValid = 1'b0;
    endtask

    // Walks the cycles after accept until the response pulse, counting pin activity.
    task automatic checkOutput(input string name, input int expLat, input logic [1:0] expCode,
                               input int expCodeCycles, input int expOeLow,
                               input bit checkD, input logic [3:0] expD);
        int lat = 0;
        int sAct = 0;
        int sHit = 0;
        int oeLow = 0;
        logic [3:0] dSeen = 4'hx;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (sPin !== 2'b00) sAct++;
            if (sPin === expCode) begin
                sHit++;
                dSeen = dPin;
            end
            if (oePin === 1'b0) oeLow++;
            if (rspValid === 1'b1) begin
                lat = cyc;
                break;
            end
        end
        checkVal({name, "_latency"}, 32'(lat), 32'(expLat));
        checkVal({name, "_s_code_cycles"}, 32'(sHit), 32'(expCodeCycles));
        checkVal({name, "_s_active_cycles"}, 32'(sAct), 32'(expCodeCycles));
        checkVal({name, "_oe_low_cycles"}, 32'(oeLow), 32'(expOeLow));
        if (checkD) checkVal({name, "_d_pins"}, 32'(dSeen), 32'(expD));
    endtask

    initial begin
        rst      = 1'b1;
        cmdValid = 1'b0;
        cmdOp    = 2'b00;
        cmdData  = 4'h0;
        cmdAmt   = 3'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkVal("reset_s", 32'(sPin), 32'd0);
        checkVal("reset_oe", 32'(oePin), 32'd1);
        checkVal("reset_rsp_valid", 32'(rspValid), 32'd0);
        checkVal("reset_rsp_data", 32'(rspData), 32'd0);
        checkVal("reset_ready", 32'(cmdReady), 32'd1);
        checkVal("reset_busy", 32'(busy), 32'd0);

        applyStimulus(2'b00, 4'b1001, 3'd0, 4'b0000);
        checkOutput("load1001", 2, 2'b11, 1, 0, 1'b1, 4'b1001);
        applyStimulus(2'b11, 4'h0, 3'd0, 4'b1001);
        checkOutput("read1001", 3, 2'b11, 0, 2, 1'b0, 4'h0);

        applyStimulus(2'b00, 4'b0001, 3'd0, 4'b1001);
        checkOutput("load0001a", 2, 2'b11, 1, 0, 1'b1, 4'b0001);
        applyStimulus(2'b01, 4'h0, 3'd1, 4'b1001);
        checkOutput("rotl1", 2, 2'b01, 1, 0, 1'b0, 4'h0);
        applyStimulus(2'b11, 4'h0, 3'd0, 4'b0010);
        checkOutput("read_rotl1", 3, 2'b11, 0, 2, 1'b0, 4'h0);

        applyStimulus(2'b00, 4'b0001, 3'd0, 4'b0010);
        checkOutput("load0001b", 2, 2'b11, 1, 0, 1'b1, 4'b0001);
        applyStimulus(2'b01, 4'h0, 3'd3, 4'b0010);
        checkOutput("rotl3_reversed", 2, 2'b10, 1, 0, 1'b0, 4'h0);
        applyStimulus(2'b11, 4'h0, 3'd0, 4'b1000);
        checkOutput("read_rotl3", 3, 2'b11, 0, 2, 1'b0, 4'h0);
        applyStimulus(2'b10, 4'h0, 3'd2, 4'b1000);
        checkOutput("rotr2_tie", 3, 2'b10, 2, 0, 1'b0, 4'h0);
        applyStimulus(2'b11, 4'h0, 3'd0, 4'b0010);
        checkOutput("read_rotr2", 3, 2'b11, 0, 2, 1'b0, 4'h0);

        applyStimulus(2'b01, 4'h0, 3'd4, 4'b0010);
        checkOutput("rotl4_noop", 1, 2'b01, 0, 0, 1'b0, 4'h0);
        applyStimulus(2'b01, 4'h0, 3'd0, 4'b0010);
        checkOutput("rotl0_noop", 1, 2'b01, 0, 0, 1'b0, 4'h0);

        // Abort a two-step rotation so that only its first shift lands.
        applyStimulus(2'b00, 4'b0001, 3'd0, 4'b0010);
        checkOutput("load0001c", 2, 2'b11, 1, 0, 1'b1, 4'b0001);
        checks++;
        assert (cmdReady === 1'b1) else begin
            errors++;
            $error("[TB] FAIL abort_ready observed=%0b expected=1", cmdReady);
        end
        cmdValid = 1'b1;
        cmdOp    = 2'b10;
        cmdAmt   = 3'd2;
        @(posedge clk);
        #1 cmdValid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkVal("abort_s_during", 32'(sPin), 32'd2);
        @(negedge clk);
        rst = 1'b0;
        checkVal("abort_s", 32'(sPin), 32'd0);
        checkVal("abort_oe", 32'(oePin), 32'd1);
        checkVal("abort_rsp_valid", 32'(rspValid), 32'd0);
        checkVal("abort_busy", 32'(busy), 32'd0);
        checkVal("abort_rsp_data", 32'(rspData), 32'd0);
        repeat (3) @(negedge clk);
        applyStimulus(2'b11, 4'h0, 3'd0, 4'b1000);
        checkOutput("read_after_abort", 3, 2'b11, 0, 2, 1'b0, 4'h0);

        // Back-to-back with CMD_VALID held high.
        cmdValid = 1'b1;
        cmdOp    = 2'b00;
        cmdData  = 4'b0110;
        expQueue.push_back(4'b1000);
        @(negedge clk);
        checkVal("b2b_load_busy", 32'(busy), 32'd1);
        checkVal("b2b_load_s", 32'(sPin), 32'd3);
        cmdOp = 2'b11;
        expQueue.push_back(4'b0110);
        @(negedge clk);
        checkVal("b2b_load_rsp", 32'(rspValid), 32'd1);
        checkVal("b2b_load_ready", 32'(cmdReady), 32'd1);
        @(negedge clk);
        checkVal("b2b_read_oe1", 32'(oePin), 32'd0);
        cmdOp  = 2'b01;
        cmdAmt = 3'd1;
        expQueue.push_back(4'b0110);
        @(negedge clk);
        checkVal("b2b_read_oe2", 32'(oePin), 32'd0);
        @(negedge clk);
        checkVal("b2b_read_rsp", 32'(rspValid), 32'd1);
        checkVal("b2b_read_ready", 32'(cmdReady), 32'd1);
        @(negedge clk);
        checkVal("b2b_rotl_s", 32'(sPin), 32'd1);
        cmdValid = 1'b0;
        @(negedge clk);
        checkVal("b2b_rotl_rsp", 32'(rspValid), 32'd1);
        applyStimulus(2'b11, 4'h0, 3'd0, 4'b1100);
        checkOutput("read_b2b", 3, 2'b11, 0, 2, 1'b0, 4'h0);

        repeat (2) @(negedge clk);
        checkVal("scoreboard_drained", 32'(expQueue.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
